// File: rtl/uart_tx_mux_fifo_if.sv
// Handshake bundle between the two byte producers, the UART transmitter and the merge FIFO.
// The slave modport is the FIFO side; the master modport is the producer/transmitter side.
interface uart_tx_mux_fifo_if #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
);
  logic             req0;
  logic [7:0]       data0;
  logic             req1;
  logic [7:0]       data1;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       sdata;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;

  modport slave (
    input  req0, data0, req1, data1, tx_busy,
    output tx_start, sdata, count, full, empty, overflow
  );

  modport master (
    output req0, data0, req1, data1, tx_busy,
    input  tx_start, sdata, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_tx_mux_fifo.sv
// Merges two single-cycle byte producers into one shared FIFO and drains it, one byte per
// transmission, into a UART transmitter that reports progress through its busy flag.
module uart_tx_mux_fifo #(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic clock,
  input  logic reset,
  uart_tx_mux_fifo_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       wait_cnt;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_second;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   free;
  logic [PTR_W:0]   need1;
  logic             overflow_q;
  logic             tx_start_q;
  logic [7:0]       sdata_q;

  logic             pop;
  logic             accept0;
  logic             accept1;
  logic             drop;

  // A slot freed by this cycle's pop is immediately reusable, so src0 still fits on a full FIFO.
  always_comb begin
    free          = (PTR_W+1)'(DEPTH) - count_q + (PTR_W+1)'(pop);
    need1         = bus.req0 ? (PTR_W+1)'(2) : (PTR_W+1)'(1);
    accept0       = bus.req0 && (free != '0);
    accept1       = bus.req1 && (free >= need1);
    drop          = (bus.req0 && !accept0) || (bus.req1 && !accept1);
    wr_ptr_second = wr_ptr + PTR_W'(accept0);
  end

  always_ff @(posedge clock) begin
    if (accept0) mem[wr_ptr] <= bus.data0;
    if (accept1) mem[wr_ptr_second] <= bus.data1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(accept0) + PTR_W'(accept1);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      count_q    <= count_q + (PTR_W+1)'(accept0) + (PTR_W+1)'(accept1) - (PTR_W+1)'(pop);
      overflow_q <= overflow_q | drop;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  // WAIT_BUSY gives up after four quiet cycles so a missed start cannot stall the queue.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)            state_next = WAIT_DONE;
        else if (wait_cnt == 2'd3)  state_next = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = (state == IDLE) && (count_q != '0) && !bus.tx_busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_start_q <= 1'b0;
      sdata_q    <= 8'h00;
    end else begin
      tx_start_q <= pop;
      if (pop) sdata_q <= mem[rd_ptr];
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.sdata    = sdata_q;
  assign bus.count    = count_q;
  assign bus.full     = (count_q == (PTR_W+1)'(DEPTH));
  assign bus.empty    = (count_q == '0);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_mux_fifo.sv
// Directed bench for uart_tx_mux_fifo: reset, merge order, overflow, wrap, reset mid-transfer
// and the missed-start timeout, with a simple busy-flag transmitter model.
module tb_uart_tx_mux_fifo;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_mux_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_mux_fifo #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         pass_cnt = 0;
  int         check_cnt = 0;
  int         start_cnt = 0;
  bit         model_en = 1'b0;
  bit         busy_pending = 1'b0;
  int         busy_left = 0;
  logic [7:0] out_q [$];
  logic [7:0] exp_q [$];

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  function automatic logic [7:0] out_at(input int k);
    if (k < out_q.size()) return out_q[k];
    return 8'hxx;
  endfunction

  // Advances n clocks; the transmitter model raises busy one cycle after a start for 20 cycles.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        out_q.push_back(bus.sdata);
      end
      if (model_en) begin
        if (bus.tx_start === 1'b1) begin
          busy_pending = 1'b1;
        end else if (busy_pending) begin
          bus.tx_busy  = 1'b1;
          busy_left    = 20;
          busy_pending = 1'b0;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.tx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic push(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
    bus.req0  = v0;
    bus.data0 = d0;
    bus.req1  = v1;
    bus.data1 = d1;
    apply_stimulus(1);
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.req0    = 1'b0;
    bus.data0   = 8'h00;
    bus.req1    = 1'b0;
    bus.data1   = 8'h00;
    bus.tx_busy = 1'b0;
    apply_stimulus(2);
    reset = 1'b0;

    // Reset state
    check_output("rst_count", bus.count, 0);
    check_output("rst_empty", bus.empty, 1);
    check_output("rst_full", bus.full, 0);
    check_output("rst_overflow", bus.overflow, 0);
    check_output("rst_tx_start", bus.tx_start, 0);
    check_output("rst_sdata", bus.sdata, 8'h00);

    // Single byte: start pulse one cycle after the push edge
    model_en = 1'b1;
    push(1'b1, 8'hA5, 1'b0, 8'h00);
    check_output("t1_count_after_push", bus.count, 1);
    check_output("t1_no_start_yet", bus.tx_start, 0);
    apply_stimulus(1);
    check_output("t1_tx_start", bus.tx_start, 1);
    check_output("t1_sdata", bus.sdata, 8'hA5);
    check_output("t1_count_after_pop", bus.count, 0);
    apply_stimulus(30);
    check_output("t1_start_count", start_cnt, 1);
    check_output("t1_sdata_held", bus.sdata, 8'hA5);
    check_output("t1_empty", bus.empty, 1);

    // Simultaneous requests: src0 first
    start_cnt = 0;
    out_q.delete();
    push(1'b1, 8'h11, 1'b1, 8'h22);
    check_output("t2_count", bus.count, 2);
    check_output("t2_overflow", bus.overflow, 0);
    apply_stimulus(60);
    check_output("t2_start_count", start_cnt, 2);
    check_output("t2_first", out_at(0), 8'h11);
    check_output("t2_second", out_at(1), 8'h22);
    check_output("t2_empty", bus.empty, 1);

    // Fill while busy, overflow on both requests, then drain in order
    start_cnt = 0;
    out_q.delete();
    model_en = 1'b0;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(1'b1, 8'(i), 1'b0, 8'h00);
    check_output("t3_full", bus.full, 1);
    check_output("t3_count_full", bus.count, 16);
    check_output("t3_overflow_before", bus.overflow, 0);
    push(1'b1, 8'hAA, 1'b1, 8'hBB);
    check_output("t3_overflow", bus.overflow, 1);
    check_output("t3_count_after_drop", bus.count, 16);
    bus.tx_busy = 1'b0;
    model_en = 1'b1;
    apply_stimulus(16 * 23 + 30);
    check_output("t3_start_count", start_cnt, 16);
    for (int i = 0; i < 16; i++) check_output("t3_order", out_at(i), 8'(i));
    check_output("t3_empty", bus.empty, 1);

    // count=15 and two requests: src0 kept, src1 dropped
    model_en = 1'b0;
    bus.tx_busy = 1'b1;
    reset = 1'b1;
    apply_stimulus(1);
    reset = 1'b0;
    check_output("t4_overflow_cleared", bus.overflow, 0);
    start_cnt = 0;
    out_q.delete();
    for (int i = 0; i < 15; i++) push(1'b1, 8'(8'h30 + i), 1'b0, 8'h00);
    check_output("t4_count15", bus.count, 15);
    push(1'b1, 8'hC0, 1'b1, 8'hC1);
    check_output("t4_count16", bus.count, 16);
    check_output("t4_overflow", bus.overflow, 1);
    check_output("t4_full", bus.full, 1);
    bus.tx_busy = 1'b0;
    model_en = 1'b1;
    apply_stimulus(16 * 23 + 30);
    check_output("t4_start_count", start_cnt, 16);
    check_output("t4_byte14", out_at(14), 8'h3E);
    check_output("t4_last_is_src0", out_at(15), 8'hC0);

    // Pointer wrap: 40 bytes in bursts of 10 while draining
    start_cnt = 0;
    out_q.delete();
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) begin
        push(1'b1, 8'(8'h50 + b * 10 + i), 1'b0, 8'h00);
        exp_q.push_back(8'(8'h50 + b * 10 + i));
      end
      apply_stimulus(260);
    end
    check_output("t5_start_count", start_cnt, 40);
    for (int i = 0; i < 40; i++) check_output("t5_order", out_at(i), exp_q[i]);
    check_output("t5_empty", bus.empty, 1);
    check_output("t5_overflow_sticky", bus.overflow, 1);

    // Reset while waiting for the transmitter with five bytes queued
    for (int i = 0; i < 6; i++) push(1'b1, 8'(8'h90 + i), 1'b0, 8'h00);
    check_output("t6_count5", bus.count, 5);
    check_output("t6_busy_model", bus.tx_busy, 1);
    reset = 1'b1;
    apply_stimulus(1);
    reset = 1'b0;
    model_en = 1'b0;
    busy_pending = 1'b0;
    busy_left = 0;
    bus.tx_busy = 1'b0;
    check_output("t6_rst_count", bus.count, 0);
    check_output("t6_rst_empty", bus.empty, 1);
    check_output("t6_rst_overflow", bus.overflow, 0);
    check_output("t6_rst_tx_start", bus.tx_start, 0);
    check_output("t6_rst_sdata", bus.sdata, 8'h00);

    // Transmitter never answers: FSM abandons WAIT_BUSY after four cycles
    push(1'b1, 8'h77, 1'b0, 8'h00);
    check_output("t6_no_start_yet", bus.tx_start, 0);
    apply_stimulus(1);
    check_output("t6_start_77", bus.tx_start, 1);
    check_output("t6_sdata_77", bus.sdata, 8'h77);
    push(1'b1, 8'h78, 1'b0, 8'h00);
    apply_stimulus(2);
    check_output("t6_wait_no_start", bus.tx_start, 0);
    apply_stimulus(1);
    check_output("t6_timeout_edge_no_start", bus.tx_start, 0);
    check_output("t6_sdata_held", bus.sdata, 8'h77);
    apply_stimulus(1);
    check_output("t6_start_78", bus.tx_start, 1);
    check_output("t6_sdata_78", bus.sdata, 8'h78);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
